switch_bank_seq: RTL and testbench

SWITCH_BANK_SEQ -- requirements
Module: switch_bank_seq

---
 rtl/switch_bank_pkg.sv | 17 +
 rtl/switch_bank_seq_timer.sv | 31 +++
 rtl/switch_bank_seq.sv | 151 +++++++++++++++
 tb/tb_switch_bank_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_bank_pkg.sv
// Shared types and default sizing for the complementary switch-bank sequencer.
package switch_bank_pkg;

  localparam int NSEG_DEF     = 16;
  localparam int BBM_DEF      = 2;
  localparam int STEP_DLY_DEF = 4;

  // Wide enough for the largest settle delay (255).
  localparam int TMR_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    SETTLE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/switch_bank_seq_timer.sv
// Loadable down-counter with a zero flag; one instance times both the
// break-before-make gap and the settle interval.
module seq_timer
  import switch_bank_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/switch_bank_seq.sv
// Thermometer-coded switch bank ramp sequencer: moves one segment at a time
// through a break-before-make gap, then waits a settle interval per step.
module switch_bank_seq
  import switch_bank_pkg::*;
#(
  parameter  int NSEG     = NSEG_DEF,
  parameter  int BBM      = BBM_DEF,
  parameter  int STEP_DLY = STEP_DLY_DEF,
  localparam int CW       = $clog2(NSEG + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CW-1:0]   target_code,
  input  logic            target_vld,
  output logic            target_rdy,
  output logic [NSEG-1:0] ng_en,
  output logic [NSEG-1:0] pg_en_b,
  output logic [CW-1:0]   cur_code,
  output logic            busy,
  output logic            done
);

  // Timer holds N-1 so a phase lasts exactly N cycles before the zero edge.
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(BBM - 1);
  localparam logic [TMR_W-1:0] STEP_LOAD = TMR_W'(STEP_DLY - 1);

  seq_state_e      state_q, state_n;
  logic [CW-1:0]   tgt_q, tgt_n;
  logic            up_q, up_n;
  logic [CW-1:0]   cur_n;
  logic [NSEG-1:0] ng_n, pg_n;
  logic            done_n;
  logic [CW-1:0]   clamped;
  logic [CW-1:0]   seg_idx;
  logic            seg_gap, seg_on, seg_off;
  logic            tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic            tmr_zero;

  seq_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n  = state_q;
    tgt_n    = tgt_q;
    up_n     = up_q;
    cur_n    = cur_code;
    ng_n     = ng_en;
    pg_n     = pg_en_b;
    done_n   = 1'b0;
    seg_idx  = '0;
    seg_gap  = 1'b0;
    seg_on   = 1'b0;
    seg_off  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    clamped  = (target_code > CW'(NSEG)) ? CW'(NSEG) : target_code;

    case (state_q)
      IDLE: begin
        if (target_vld) begin
          tgt_n = clamped;
          if (clamped == cur_code) begin
            done_n = 1'b1;
          end else begin
            up_n     = (clamped > cur_code);
            seg_idx  = up_n ? cur_code : cur_code - CW'(1);
            seg_gap  = 1'b1;
            state_n  = GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (tmr_zero) begin
          seg_idx  = up_q ? cur_code : cur_code - CW'(1);
          seg_on   = up_q;
          seg_off  = !up_q;
          cur_n    = up_q ? cur_code + CW'(1) : cur_code - CW'(1);
          state_n  = SETTLE;
          tmr_load = 1'b1;
          tmr_val  = STEP_LOAD;
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          if (cur_code == tgt_q) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            seg_idx  = up_q ? cur_code : cur_code - CW'(1);
            seg_gap  = 1'b1;
            state_n  = GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // GAP drives both gates off; ng never rises while pg_en_b is low.
    for (int k = 0; k < NSEG; k++) begin
      if (CW'(k) == seg_idx) begin
        if (seg_gap) begin
          ng_n[k] = 1'b0;
          pg_n[k] = 1'b1;
        end else if (seg_on) begin
          ng_n[k] = 1'b1;
          pg_n[k] = 1'b1;
        end else if (seg_off) begin
          ng_n[k] = 1'b0;
          pg_n[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      up_q       <= 1'b0;
      cur_code   <= '0;
      ng_en      <= '0;
      pg_en_b    <= '0;
      done       <= 1'b0;
      target_rdy <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_n;
      tgt_q      <= tgt_n;
      up_q       <= up_n;
      cur_code   <= cur_n;
      ng_en      <= ng_n;
      pg_en_b    <= pg_n;
      done       <= done_n;
      target_rdy <= (state_n == IDLE);
      busy       <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_switch_bank_seq.sv
// Self-checking bench for switch_bank_seq: timing model per cycle plus a
// scoreboard of expected done cycle and final code per request.
module tb_switch_bank_seq;

  localparam int NSEG     = 16;
  localparam int BBM      = 2;
  localparam int STEP_DLY = 4;
  localparam int CW       = $clog2(NSEG + 1);
  localparam int T        = BBM + STEP_DLY;

  logic            clk = 1'b0;
  logic            rst;
  logic [CW-1:0]   target_code;
  logic            target_vld;
  logic            target_rdy;
  logic [NSEG-1:0] ng_en;
  logic [NSEG-1:0] pg_en_b;
  logic [CW-1:0]   cur_code;
  logic            busy;
  logic            done;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  typedef struct {
    int done_cycle;
    int code;
  } exp_t;
  exp_t sb_q[$];

  switch_bank_seq #(.NSEG(NSEG), .BBM(BBM), .STEP_DLY(STEP_DLY)) dut (
    .clk         (clk),
    .rst         (rst),
    .target_code (target_code),
    .target_vld  (target_vld),
    .target_rdy  (target_rdy),
    .ng_en       (ng_en),
    .pg_en_b     (pg_en_b),
    .cur_code    (cur_code),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [NSEG-1:0] on_mask(input int n);
    logic [NSEG-1:0] m;
    for (int k = 0; k < NSEG; k++) m[k] = (k < n);
    return m;
  endfunction

  // Gate-drive invariants, evaluated every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if ((ng_en & ~pg_en_b) != '0) begin
        n_fail++;
        $display("FAIL shoot_through: ng_en=%h pg_en_b=%h, required no bit with ng=1 and pg_en_b=0",
                 ng_en, pg_en_b);
      end
      n_checks++;
      if ($countones(~ng_en & pg_en_b) > 1) begin
        n_fail++;
        $display("FAIL multi_gap: %0d segments in GAP, required at most 1",
                 $countones(~ng_en & pg_en_b));
      end
    end
  end

  task automatic run_ramp(input string name, input int from, input int req);
    int to, n, last, dir, d, s, p, cur, gap;
    logic [NSEG-1:0] exp_ng, exp_pg;
    logic exp_rdy, exp_done;
    exp_t e;
    to   = (req > NSEG) ? NSEG : req;
    n    = (to > from) ? to - from : from - to;
    dir  = (to > from) ? 1 : -1;
    last = n * T + 1;
    e.done_cycle = last;
    e.code       = to;
    sb_q.push_back(e);

    @(negedge clk);
    target_code = CW'(req);
    target_vld  = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= last + 2; c++) begin
      @(negedge clk);
      if (c == 1) target_vld = 1'b0;
      if (c == 2 && last > 4) begin
        target_vld  = 1'b1;
        target_code = CW'((to + 3) % (NSEG + 1));
      end
      if (c == 3) target_vld = 1'b0;

      d   = c - 1;
      gap = -1;
      if (d >= n * T) begin
        cur = to;
      end else begin
        s = d / T;
        p = d % T;
        if (p < BBM) begin
          cur = from + dir * s;
          gap = (dir > 0) ? cur : cur - 1;
        end else begin
          cur = from + dir * (s + 1);
        end
      end
      exp_ng = on_mask(cur);
      exp_pg = on_mask(cur);
      if (gap >= 0) begin
        exp_ng[gap] = 1'b0;
        exp_pg[gap] = 1'b1;
      end
      exp_rdy  = (c >= last);
      exp_done = (c == last);

      n_checks++;
      if ({ng_en, pg_en_b, cur_code, target_rdy, busy, done} !==
          {exp_ng, exp_pg, CW'(cur), exp_rdy, !exp_rdy, exp_done}) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got ng=%h pg_b=%h cur=%0d rdy=%b busy=%b done=%b, expected ng=%h pg_b=%h cur=%0d rdy=%b busy=%b done=%b",
                 name, c, ng_en, pg_en_b, cur_code, target_rdy, busy, done,
                 exp_ng, exp_pg, cur, exp_rdy, !exp_rdy, exp_done);
      end

      if (done === 1'b1) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s sb_unexpected_done: got done at cycle %0d, expected none", name, c);
        end else begin
          e = sb_q.pop_front();
          if (c != e.done_cycle || int'(cur_code) != e.code) begin
            n_fail++;
            $display("FAIL %s sb_done: got cycle %0d code %0d, expected cycle %0d code %0d",
                     name, c, cur_code, e.done_cycle, e.code);
          end
        end
      end
    end

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s sb_timeout: got no done within %0d cycles, expected done at cycle %0d",
               name, last + 2, last);
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    target_vld  = 1'b0;
    target_code = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({ng_en, pg_en_b, cur_code, target_rdy, busy, done} !==
        {{NSEG{1'b0}}, {NSEG{1'b0}}, CW'(0), 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got ng=%h pg_b=%h cur=%0d rdy=%b busy=%b done=%b, expected all zero with rdy=1",
               ng_en, pg_en_b, cur_code, target_rdy, busy, done);
    end
    rst    = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic test_ramp_up();
    run_ramp("ramp_up_0_to_2", 0, 2);
  endtask

  task automatic test_ramp_down();
    run_ramp("ramp_down_2_to_0", 2, 0);
  endtask

  task automatic test_clamp();
    run_ramp("clamp_20_to_16", 0, 20);
  endtask

  task automatic test_equal();
    run_ramp("ramp_down_16_to_5", 16, 5);
    run_ramp("equal_5", 5, 5);
  endtask

  task automatic test_back_to_back();
    run_ramp("b2b_5_to_7", 5, 7);
    run_ramp("b2b_7_to_6", 7, 6);
  endtask

  task automatic test_reset_mid_ramp();
    int done_seen;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    target_code = CW'(8);
    target_vld  = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c == 1) target_vld = 1'b0;
    end
    n_checks++;
    if (ng_en !== on_mask(3) || pg_en_b !== on_mask(4) || cur_code !== CW'(3)) begin
      n_fail++;
      $display("FAIL mid_rst_seg3_gap: got ng=%h pg_b=%h cur=%0d, expected ng=%h pg_b=%h cur=3",
               ng_en, pg_en_b, cur_code, on_mask(3), on_mask(4));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({ng_en, pg_en_b, cur_code, target_rdy, busy, done} !==
        {{NSEG{1'b0}}, {NSEG{1'b0}}, CW'(0), 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_rst_state: got ng=%h pg_b=%h cur=%0d rdy=%b busy=%b done=%b, expected all zero with rdy=1",
               ng_en, pg_en_b, cur_code, target_rdy, busy, done);
    end
    done_seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done === 1'b1 || target_rdy !== 1'b1 || cur_code !== CW'(0)) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) begin
      n_fail++;
      $display("FAIL mid_rst_quiet: got %0d cycles with done or activity after reset, expected 0",
               done_seen);
    end
  endtask

  initial begin
    rst         = 1'b1;
    target_vld  = 1'b0;
    target_code = '0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_clamp();
    test_equal();
    test_back_to_back();
    test_reset_mid_ramp();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
